// File: rtl/param_fifo.sv
// Synchronous FIFO with registered read data, status flags and
// per-edge handshake results exposed as a small state code.
module param_fifo #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [WIDTH-1:0]           d_in,
  output logic [WIDTH-1:0]           d_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       wr_ack,
  output logic                       wr_err,
  output logic                       rd_ack,
  output logic                       rd_err,
  output logic [$clog2(DEPTH):0]     data_count,
  output logic [2:0]                 state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  typedef enum logic [2:0] {
    S_INIT   = 3'b000,
    S_WRITE  = 3'b001,
    S_WR_ERR = 3'b010,
    S_NO_OP  = 3'b011,
    S_READ   = 3'b100,
    S_RD_ERR = 3'b101,
    S_RDWR   = 3'b110
  } state_e;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  state_e           state_q, state_d;
  logic             wa_q, wa_d;
  logic             we_q, we_d;
  logic             ra_q, ra_d;
  logic             re_q, re_d;

  logic             do_wr;
  logic             do_rd;

  assign full         = (cnt_q == FULL_CNT);
  assign empty        = (cnt_q == '0);
  assign almost_full  = (cnt_q >= AF_CNT);
  assign almost_empty = (cnt_q <= AE_CNT);

  // A write into a full FIFO is still taken when a read frees the slot.
  assign do_wr = wr_en & (~full | rd_en);
  assign do_rd = rd_en & ~empty;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    state_d = state_q;
    wa_d    = 1'b0;
    we_d    = 1'b0;
    ra_d    = 1'b0;
    re_d    = 1'b0;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      cnt_d   = '0;
      state_d = S_INIT;
    end else begin
      if (do_wr) begin
        tail_d = tail_q + AW'(1);
      end
      if (do_rd) begin
        head_d = head_q + AW'(1);
        dout_d = mem_q[head_q];
      end
      cnt_d = cnt_q + CW'(do_wr) - CW'(do_rd);
      wa_d  = do_wr;
      we_d  = wr_en & ~do_wr;
      ra_d  = do_rd;
      re_d  = rd_en & ~do_rd;
      unique case ({wr_en, rd_en})
        2'b11:   state_d = empty ? S_WRITE : S_RDWR;
        2'b10:   state_d = full ? S_WR_ERR : S_WRITE;
        2'b01:   state_d = empty ? S_RD_ERR : S_READ;
        default: state_d = S_NO_OP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      state_q <= S_INIT;
      wa_q    <= 1'b0;
      we_q    <= 1'b0;
      ra_q    <= 1'b0;
      re_q    <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      state_q <= state_d;
      wa_q    <= wa_d;
      we_q    <= we_d;
      ra_q    <= ra_d;
      re_q    <= re_d;
    end
  end

  // Storage is never cleared; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (!reset && !flush && do_wr) begin
      mem_q[tail_q] <= d_in;
    end
  end

  assign d_out      = dout_q;
  assign data_count = cnt_q;
  assign state      = state_q;
  assign wr_ack     = wa_q;
  assign wr_err     = we_q;
  assign rd_ack     = ra_q;
  assign rd_err     = re_q;

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo: stimulus pushes expected results,
// a monitor pops and compares them one cycle after each edge.
module tb_param_fifo;

  localparam logic [2:0] INIT = 3'b000;
  localparam logic [2:0] WR   = 3'b001;
  localparam logic [2:0] WE   = 3'b010;
  localparam logic [2:0] NOP  = 3'b011;
  localparam logic [2:0] RD   = 3'b100;
  localparam logic [2:0] RE   = 3'b101;
  localparam logic [2:0] RW   = 3'b110;

  localparam logic [3:0] H_WA = 4'b1000;
  localparam logic [3:0] H_WE = 4'b0100;
  localparam logic [3:0] H_RA = 4'b0010;
  localparam logic [3:0] H_RE = 4'b0001;

  typedef struct {
    logic [2:0]  st;
    logic [3:0]  cnt;
    logic [3:0]  hs;
    logic [31:0] dout;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] d_in = '0;
  logic [31:0] d_out;
  logic        full, empty, almost_full, almost_empty;
  logic        wr_ack, wr_err, rd_ack, rd_err;
  logic [3:0]  data_count;
  logic [2:0]  state;

  int total = 0;
  int bad = 0;
  exp_t q[$];

  param_fifo #(
    .WIDTH(32), .DEPTH(8), .AF_LEVEL(7), .AE_LEVEL(1)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .wr_en(wr_en), .rd_en(rd_en), .d_in(d_in),
    .d_out(d_out), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .wr_ack(wr_ack), .wr_err(wr_err),
    .rd_ack(rd_ack), .rd_err(rd_err),
    .data_count(data_count), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic step(input logic rs, input logic fl,
                      input logic we, input logic re,
                      input logic [31:0] din, input logic [2:0] st,
                      input int cnt, input logic [3:0] hs,
                      input logic [31:0] dout);
    exp_t e;
    @(negedge clk);
    reset = rs;
    flush = fl;
    wr_en = we;
    rd_en = re;
    d_in  = din;
    e.st   = st;
    e.cnt  = 4'(cnt);
    e.hs   = hs;
    e.dout = dout;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("state", 32'(state), 32'(e.st));
        chk("count", 32'(data_count), 32'(e.cnt));
        chk("handshake", 32'({wr_ack, wr_err, rd_ack, rd_err}),
            32'(e.hs));
        chk("d_out", d_out, e.dout);
        chk("flags", 32'({full, empty, almost_full, almost_empty}),
            32'({e.cnt == 8, e.cnt == 0, e.cnt >= 7, e.cnt <= 1}));
      end
    end
  end

  initial begin : stim
    int guard;
    step(1, 0, 0, 0, 0, INIT, 0, 4'b0, 0);
    step(0, 0, 0, 0, 0, NOP, 0, 4'b0, 0);
    // fill and overflow
    for (int i = 0; i < 8; i++)
      step(0, 0, 1, 0, 32'h11 * (i + 1), WR, i + 1, H_WA, 0);
    step(0, 0, 1, 0, 32'h99, WE, 8, H_WE, 0);
    // drain and underflow
    for (int i = 0; i < 8; i++)
      step(0, 0, 0, 1, 0, RD, 7 - i, H_RA, 32'h11 * (i + 1));
    step(0, 0, 0, 1, 0, RE, 0, H_RE, 32'h88);
    // pointer wrap
    for (int i = 0; i < 6; i++)
      step(0, 0, 1, 0, 32'h01 + i, WR, i + 1, H_WA, 32'h88);
    for (int i = 0; i < 6; i++)
      step(0, 0, 0, 1, 0, RD, 5 - i, H_RA, 32'h01 + i);
    for (int i = 0; i < 8; i++)
      step(0, 0, 1, 0, 32'hA0 + i, WR, i + 1, H_WA, 32'h06);
    for (int i = 0; i < 8; i++)
      step(0, 0, 0, 1, 0, RD, 7 - i, H_RA, 32'hA0 + i);
    // simultaneous read/write
    step(0, 0, 1, 1, 32'h55, WR, 1, H_WA | H_RE, 32'hA7);
    step(0, 0, 1, 1, 32'h66, RW, 1, H_WA | H_RA, 32'h55);
    for (int i = 0; i < 7; i++)
      step(0, 0, 1, 0, 32'h70 + i, WR, i + 2, H_WA, 32'h55);
    step(0, 0, 1, 1, 32'h77, RW, 8, H_WA | H_RA, 32'h66);
    // flush at count 5 with a write pending
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 1, 0, RD, 7 - i, H_RA, 32'h70 + i);
    step(0, 1, 1, 0, 32'hEE, INIT, 0, 4'b0, 32'h72);
    step(0, 0, 0, 1, 0, RE, 0, H_RE, 32'h72);
    // reset overrides flush mid-operation
    for (int i = 0; i < 3; i++)
      step(0, 0, 1, 0, 32'hB1 + i, WR, i + 1, H_WA, 32'h72);
    step(1, 1, 1, 0, 32'hCC, INIT, 0, 4'b0, 0);
    step(0, 0, 0, 1, 0, RE, 0, H_RE, 0);
    step(0, 0, 0, 0, 0, NOP, 0, 4'b0, 0);
    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge clk);
      #2;
      guard++;
    end
    total++;
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expected entries unchecked", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
